conv3x3_mac: RTL and testbench

Pipelined 3×3 convolution datapath that sits directly downstream of the `Fsmv` address/control FSM in the 2D-convolution engine. It accepts one vertical 3-pixel column per `o_fms2conVld` strobe (pixels read from image memory at `o_readAdd`), holds a sliding 3×3 window, multiplies it by a loadable signed kernel, and produces one scaled, saturated output pixel per window. The output pixel is written back to memory at the FSM's `o_writeAdd`. `o_changeBlock` from the FSM restarts window filling.

---
 rtl/conv3x3_mac.sv | 142 ++++++++++++++
 tb/tb_conv3x3_mac.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// Pipelined 3x3 convolution: sliding window fed one column per strobe,
// loadable signed kernel, scaled and saturated unsigned output pixel.
module conv3x3_mac #(
  parameter int NB_DATA  = 8,
  parameter int NB_COEFF = 8,
  parameter int NB_OUT   = 8,
  parameter int SHIFT    = 4
) (
  input  logic                    i_CLK,
  input  logic                    i_reset,
  input  logic [3*NB_DATA-1:0]    i_column,
  input  logic                    i_valid,
  input  logic                    i_changeBlock,
  input  logic                    i_kernelWe,
  input  logic [3:0]              i_kernelAddr,
  input  logic [NB_COEFF-1:0]     i_kernelData,
  output logic [NB_OUT-1:0]       o_pixel,
  output logic                    o_valid
);

  localparam int NB_PROD = NB_DATA + NB_COEFF + 1;
  localparam int NB_ACC  = NB_DATA + NB_COEFF + 5;
  localparam logic signed [NB_COEFF-1:0] COEFF_ONE = NB_COEFF'(1 << SHIFT);
  localparam logic signed [NB_ACC-1:0]   PIX_MAX   = NB_ACC'((1 << NB_OUT) - 1);

  logic [NB_DATA-1:0]        win_reg [9];
  logic [NB_DATA-1:0]        col_row [3];
  logic [1:0]                fill_reg;
  logic [1:0]                fill_next;
  logic                      launch;
  logic                      s1_valid_reg;
  logic                      s2_valid_reg;
  logic                      s3_valid_reg;
  logic signed [NB_PROD-1:0] prod_w [9];
  logic signed [NB_ACC-1:0]  sum_next;
  logic signed [NB_ACC-1:0]  sum_reg;
  logic signed [NB_ACC-1:0]  shifted;
  logic [NB_OUT-1:0]         sat_pixel;
  logic [NB_OUT-1:0]         pixel_reg;
  logic                      valid_reg;

  // Row 0 (top) sits in the MSBs of the incoming column.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign col_row[gi] = i_column[(3-gi)*NB_DATA-1 -: NB_DATA];
  end

  always_comb begin
    fill_next = fill_reg;
    launch    = 1'b0;
    if (i_changeBlock) begin
      fill_next = i_valid ? 2'd1 : 2'd0;
    end else if (i_valid) begin
      fill_next = (fill_reg == 2'd3) ? 2'd3 : fill_reg + 2'd1;
      launch    = (fill_reg >= 2'd2);
    end
  end

  // S1: window, index 3*row+col, col 2 is the newest column.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 9; i++) win_reg[i] <= '0;
      fill_reg     <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      fill_reg     <= fill_next;
      s1_valid_reg <= launch;
      for (int r = 0; r < 3; r++) begin
        if (i_changeBlock) begin
          win_reg[3*r]   <= '0;
          win_reg[3*r+1] <= '0;
          win_reg[3*r+2] <= i_valid ? col_row[r] : '0;
        end else if (i_valid) begin
          win_reg[3*r]   <= win_reg[3*r+1];
          win_reg[3*r+1] <= win_reg[3*r+2];
          win_reg[3*r+2] <= col_row[r];
        end
      end
    end
  end

  // S2: one coefficient register and one product register per tap.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    logic signed [NB_COEFF-1:0] coeff_reg;
    logic signed [NB_PROD-1:0]  prod_reg;
    logic signed [NB_PROD-1:0]  pix_ext;
    logic signed [NB_PROD-1:0]  coeff_ext;

    assign pix_ext   = NB_PROD'(signed'({1'b0, win_reg[gi]}));
    assign coeff_ext = NB_PROD'(coeff_reg);

    always_ff @(posedge i_CLK or negedge i_reset) begin
      if (!i_reset) begin
        coeff_reg <= (gi == 4) ? COEFF_ONE : '0;
        prod_reg  <= '0;
      end else begin
        if (i_kernelWe && (i_kernelAddr == 4'(gi)))
          coeff_reg <= i_kernelData;
        if (s1_valid_reg)
          prod_reg <= pix_ext * coeff_ext;
      end
    end

    assign prod_w[gi] = prod_reg;
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < 9; i++) sum_next = sum_next + NB_ACC'(prod_w[i]);
  end

  assign shifted = sum_reg >>> SHIFT;

  always_comb begin
    if (shifted[NB_ACC-1])
      sat_pixel = '0;
    else if (shifted > PIX_MAX)
      sat_pixel = '1;
    else
      sat_pixel = shifted[NB_OUT-1:0];
  end

  // S3 sum and S4 saturated output; output pixel holds between strobes.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      sum_reg      <= '0;
      valid_reg    <= 1'b0;
      pixel_reg    <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      valid_reg    <= s3_valid_reg;
      if (s2_valid_reg) sum_reg   <= sum_next;
      if (s3_valid_reg) pixel_reg <= sat_pixel;
    end
  end

  assign o_pixel = pixel_reg;
  assign o_valid = valid_reg;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: directed test-plan steps followed by
// random streaming, compared against a column-queue reference model.
module tb_conv3x3_mac;

  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] column;
  logic        valid;
  logic        cb;
  logic        kwe;
  logic [3:0]  kaddr;
  logic [7:0]  kdata;
  logic [7:0]  pixel;
  logic        ovalid;

  always #5 clk = ~clk;

  conv3x3_mac #(
    .NB_DATA(8), .NB_COEFF(8), .NB_OUT(8), .SHIFT(SHIFT)
  ) dut (
    .i_CLK(clk),
    .i_reset(rst_n),
    .i_column(column),
    .i_valid(valid),
    .i_changeBlock(cb),
    .i_kernelWe(kwe),
    .i_kernelAddr(kaddr),
    .i_kernelData(kdata),
    .o_pixel(pixel),
    .o_valid(ovalid)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  int last_out = 0;
  int mark;

  logic [23:0] cols[$];
  int          cap_pix[9];
  bit          cap_vld;
  int          kern[9];
  int          due_q[$];
  int          val_q[$];
  bit          exp_v;
  int          exp_pix;

  function automatic int pix_of(logic [23:0] c, int r);
    logic [23:0] s;
    s = c >> (8 * (2 - r));
    return int'(s[7:0]);
  endfunction

  function automatic void model_reset();
    cols.delete();
    due_q.delete();
    val_q.delete();
    cap_vld = 1'b0;
    for (int i = 0; i < 9; i++) kern[i] = 0;
    kern[4] = 1 << SHIFT;
    exp_v   = 1'b0;
    exp_pix = 0;
  endfunction

  // One rising edge of the reference: convolve the window captured on the
  // previous edge with the kernel as it stands before this edge's write.
  function automatic void model_edge(bit v, logic [23:0] c, bit b, bit we,
                                     logic [3:0] a, logic [7:0] d);
    int acc;
    int res;
    cyc++;
    if (cap_vld) begin
      acc = 0;
      for (int i = 0; i < 9; i++) acc += cap_pix[i] * kern[i];
      res = acc >>> SHIFT;
      if (res < 0) res = 0;
      else if (res > 255) res = 255;
      due_q.push_back(cyc + 2);
      val_q.push_back(res);
    end
    cap_vld = 1'b0;
    if (we && a <= 4'd8) kern[a] = int'($signed(d));
    if (b) begin
      cols.delete();
      if (v) cols.push_back(c);
    end else if (v) begin
      cols.push_back(c);
      if (cols.size() > 3) void'(cols.pop_front());
      if (cols.size() == 3) begin
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++)
            cap_pix[3*r+k] = pix_of(cols[k], r);
        cap_vld = 1'b1;
      end
    end
    exp_v = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      exp_pix = val_q.pop_front();
      exp_v   = 1'b1;
    end
  endfunction

  task automatic compare_outputs(input string tag);
    total++;
    assert (ovalid === exp_v)
      else begin
        bad++;
        $error("FAIL %s o_valid got=%0b exp=%0b cyc=%0d", tag, ovalid, exp_v, cyc);
      end
    total++;
    assert (pixel === 8'(exp_pix))
      else begin
        bad++;
        $error("FAIL %s o_pixel got=%0d exp=%0d cyc=%0d", tag, pixel, exp_pix, cyc);
      end
    if (ovalid === 1'b1) begin
      out_cnt++;
      last_out = int'(pixel);
      $display("%s: out cyc=%0d pixel=%0d", tag, cyc, pixel);
    end
  endtask

  task automatic drive(input bit v, input logic [23:0] c, input bit b, input bit we,
                       input logic [3:0] a, input logic [7:0] d, input string tag);
    valid  = v;
    column = c;
    cb     = b;
    kwe    = we;
    kaddr  = a;
    kdata  = d;
    @(posedge clk);
    model_edge(v, c, b, we, a, d);
    #1;
    compare_outputs(tag);
  endtask

  task automatic col_step(input bit v, input logic [23:0] c, input bit b, input string tag);
    drive(v, c, b, 1'b0, 4'd0, 8'd0, tag);
  endtask

  task automatic kwrite(input logic [3:0] a, input logic [7:0] d);
    drive(1'b0, 24'd0, 1'b0, 1'b1, a, d, "kwrite");
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) col_step(1'b0, 24'd0, 1'b0, tag);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
  endtask

  task automatic do_reset(input string tag);
    valid = 1'b0; cb = 1'b0; kwe = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs(tag);
    @(posedge clk);
    #1;
    compare_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; cb = 1'b0; kwe = 1'b0;
    column = '0; kaddr = '0; kdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity kernel: single output, centre pixel of the window
    out_cnt = 0;
    col_step(1'b1, {8'd10, 8'd20, 8'd30}, 1'b0, "ident");
    col_step(1'b1, {8'd40, 8'd50, 8'd60}, 1'b0, "ident");
    col_step(1'b1, {8'd70, 8'd80, 8'd90}, 1'b0, "ident");
    idle(4, "ident");
    check_int("ident_count", out_cnt, 1);
    check_int("ident_value", last_out, 50);

    // Box kernel
    for (int i = 0; i < 9; i++) kwrite(4'(i), 8'd1);
    col_step(1'b0, 24'd0, 1'b1, "box");
    out_cnt = 0;
    for (int i = 0; i < 5; i++) col_step(1'b1, {8'd160, 8'd160, 8'd160}, 1'b0, "box");
    idle(4, "box");
    check_int("box_count", out_cnt, 3);
    check_int("box_value", last_out, 90);

    // Positive saturation
    for (int i = 0; i < 9; i++) kwrite(4'(i), 8'd127);
    col_step(1'b0, 24'd0, 1'b1, "satp");
    for (int i = 0; i < 3; i++) col_step(1'b1, 24'hFFFFFF, 1'b0, "satp");
    idle(4, "satp");
    check_int("satp_value", last_out, 255);

    // Negative saturation
    for (int i = 0; i < 9; i++) kwrite(4'(i), (i == 4) ? 8'h80 : 8'h00);
    col_step(1'b0, 24'd0, 1'b1, "satn");
    out_cnt = 0;
    for (int i = 0; i < 3; i++) col_step(1'b1, 24'hFFFFFF, 1'b0, "satn");
    idle(4, "satn");
    check_int("satn_count", out_cnt, 1);
    check_int("satn_value", last_out, 0);

    // changeBlock with in-flight windows
    kwrite(4'd4, 8'd16);
    col_step(1'b0, 24'd0, 1'b1, "chblk");
    out_cnt = 0;
    for (int i = 0; i < 4; i++) col_step(1'b1, 24'($urandom), 1'b0, "chblk");
    col_step(1'b1, 24'($urandom), 1'b1, "chblk");
    for (int i = 0; i < 2; i++) col_step(1'b1, 24'($urandom), 1'b0, "chblk");
    idle(4, "chblk");
    check_int("chblk_count", out_cnt, 3);

    // Gapped valid
    col_step(1'b0, 24'd0, 1'b1, "gap");
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      col_step(1'b1, 24'($urandom), 1'b0, "gap");
      col_step(1'b0, 24'($urandom), 1'b0, "gap");
    end
    idle(4, "gap");
    check_int("gap_count", out_cnt, 6);

    // Out-of-range coefficient addresses are ignored
    kwrite(4'd9, 8'h55);
    kwrite(4'd15, 8'h7F);
    col_step(1'b0, 24'd0, 1'b1, "badaddr");
    col_step(1'b1, {8'd10, 8'd20, 8'd30}, 1'b0, "badaddr");
    col_step(1'b1, {8'd40, 8'd50, 8'd60}, 1'b0, "badaddr");
    col_step(1'b1, {8'd70, 8'd80, 8'd90}, 1'b0, "badaddr");
    idle(4, "badaddr");
    check_int("badaddr_value", last_out, 50);

    // Reset one cycle after a launch discards the result
    col_step(1'b0, 24'd0, 1'b1, "midrst");
    for (int i = 0; i < 3; i++) col_step(1'b1, 24'($urandom_range(1, 24'hFFFFFF)), 1'b0, "midrst");
    col_step(1'b0, 24'd0, 1'b0, "midrst");
    mark = out_cnt;
    do_reset("midrst");
    idle(5, "midrst");
    check_int("midrst_count", out_cnt, mark);

    // Random streaming with kernel updates and block changes
    for (int i = 0; i < 400; i++) begin
      bit          v;
      bit          b;
      bit          we;
      logic [3:0]  a;
      logic [7:0]  d;
      v  = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 29) == 0);
      we = ($urandom_range(0, 9) == 0);
      a  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16) - 8);
      drive(v, 24'($urandom), b, we, a, d, "rand");
    end
    idle(4, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
